// File: rtl/dsa_pkg.sv
// Shared definitions for the digit-serial adder.
//  - FSM state encoding (fixed numeric codes plus a typed enum built on them)
//  - cnt_width(): digit-counter width, clog2(ndig) with a floor of 1 bit
package dsa_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned ndig);
    int unsigned w;
    w = (ndig <= 1) ? 1 : int'($clog2(ndig));
    return w;
  endfunction

endpackage

// File: rtl/digit_serial_add_if.sv
// Handshake bundle of the digit-serial adder.
//  master: operand producer / result consumer (drives in_valid, a, b, cin, out_ready)
//  slave : the adder (drives in_ready, out_valid, c, cout)
interface digit_serial_add_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, c, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, c, cout
  );

endinterface

// File: rtl/digit_add.sv
// Combinational DIGIT-bit adder: {cout, c} = a + b + cin.
// Kept as a separate cell so a library ADD_DIGIT_DIGIT primitive can replace it.
//  a, b : DIGIT-bit addends
//  cin  : carry-in
//  c    : DIGIT-bit sum
//  cout : carry out of bit DIGIT-1
module digit_add #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] c,
  output logic             cout
);

  always_comb begin
    {cout, c} = {1'b0, a} + {1'b0, b} + (DIGIT + 1)'(cin);
  end

endmodule

// File: rtl/digit_serial_add.sv
// Digit-serial adder: c = a + b + cin with carry-out, DIGIT bits per clock.
// Operands are captured on the input handshake, summed LSB digit first over
// NDIG = WIDTH/DIGIT clocks, then the result is held until the output handshake.
//  clk, rst_n : rising-edge clock, asynchronous active-low reset
//  bus        : slave side of digit_serial_add_if
//               in_valid/in_ready + a, b, cin   -> operands
//               out_valid/out_ready + c, cout   -> result
module digit_serial_add
  import dsa_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  digit_serial_add_if.slave      bus
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_cout;
  logic [WIDTH+DIGIT-1:0] res_cat;

  digit_add #(
    .DIGIT (DIGIT)
  ) u_digit_add (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .c    (dig_sum),
    .cout (dig_cout)
  );

  // New digit enters at the MSB end; after NDIG shifts digit 0 sits at the LSB.
  // Works for DIGIT == WIDTH too, where the whole register is replaced.
  assign res_cat = {dig_sum, res_q};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid)              state_d = StRun;
      StRun:  if (cnt_q == CW'(NDIG - 1))    state_d = StDone;
      StDone: if (bus.out_ready)             state_d = StIdle;
      default:                               state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
  end

  // Result and carry registers feed the outputs directly; they only move in
  // RUN, so they stay stable through DONE and keep their value in IDLE.
  // The carry register is loaded with cin on accept, so cout is only
  // meaningful while out_valid is high.
  assign bus.c    = res_q;
  assign bus.cout = carry_q;

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_digit_serial_add.sv
// Self-checking bench: instance 0 is WIDTH=8/DIGIT=2, instance 1 is WIDTH=8/DIGIT=8.
// Expected sums come from plain 9-bit arithmetic on the operands.
module tb_digit_serial_add;

  logic clk;
  logic rst0, rst1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  digit_serial_add_if #(.WIDTH(8)) bus0 ();
  digit_serial_add_if #(.WIDTH(8)) bus1 ();

  digit_serial_add #(.WIDTH(8), .DIGIT(2)) dut0 (.clk(clk), .rst_n(rst0), .bus(bus0));
  digit_serial_add #(.WIDTH(8), .DIGIT(8)) dut1 (.clk(clk), .rst_n(rst1), .bus(bus1));

  // Per-instance drive / observe arrays, index 0 -> dut0, 1 -> dut1
  logic       iv [2];
  logic       ordy [2];
  logic [7:0] av [2];
  logic [7:0] bv [2];
  logic       cv [2];
  wire        ov [2];
  wire        ir [2];
  wire        co [2];
  wire  [7:0] cr [2];

  assign bus0.in_valid  = iv[0];
  assign bus0.a         = av[0];
  assign bus0.b         = bv[0];
  assign bus0.cin       = cv[0];
  assign bus0.out_ready = ordy[0];
  assign ov[0] = bus0.out_valid;
  assign ir[0] = bus0.in_ready;
  assign co[0] = bus0.cout;
  assign cr[0] = bus0.c;

  assign bus1.in_valid  = iv[1];
  assign bus1.a         = av[1];
  assign bus1.b         = bv[1];
  assign bus1.cin       = cv[1];
  assign bus1.out_ready = ordy[1];
  assign ov[1] = bus1.out_valid;
  assign ir[1] = bus1.in_ready;
  assign co[1] = bus1.cout;
  assign cr[1] = bus1.c;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full operation: accept, wait bounded for out_valid, compare, handshake out.
  task automatic do_op(input int s, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input string tag, output logic [7:0] c_o, output logic co_o,
                       output time t_acc);
    logic [8:0] sum;
    int         cyc;
    int         ndig;
    ndig = (s == 0) ? 4 : 1;
    sum  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(ir[s]), 32'd1);
    iv[s] = 1'b1;
    av[s] = a;
    bv[s] = b;
    cv[s] = cin;
    @(posedge clk);
    t_acc = $time;
    #1;
    // Scramble operands: the op in flight must not see them
    iv[s] = 1'b0;
    av[s] = 8'($urandom);
    bv[s] = 8'($urandom);
    cv[s] = 1'($urandom);
    cyc = 0;
    while (!ov[s] && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(ndig));
    check({tag, "_c"}, 32'(cr[s]), 32'(sum[7:0]));
    check({tag, "_cout"}, 32'(co[s]), 32'(sum[8]));
    c_o  = cr[s];
    co_o = co[s];
    ordy[s] = 1'b1;
    @(posedge clk);
    #1;
    ordy[s] = 1'b0;
    check({tag, "_ov_drop"}, 32'(ov[s]), 32'd0);
    check({tag, "_ir_back"}, 32'(ir[s]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] c_r;
    logic       co_r;
    time        t0, t1;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] d;
    int         cyc;

    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; av[i] = '0; bv[i] = '0; cv[i] = 1'b0;
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_in_ready", i), 32'(ir[i]), 32'd1);
      check($sformatf("rst%0d_out_valid", i), 32'(ov[i]), 32'd0);
      check($sformatf("rst%0d_c", i), 32'(cr[i]), 32'd0);
      check($sformatf("rst%0d_cout", i), 32'(co[i]), 32'd0);
    end
    @(negedge clk);
    rst0 = 1'b1;
    rst1 = 1'b1;

    // Directed vectors
    do_op(0, 8'h5A, 8'h3C, 1'b0, "t1", c_r, co_r, t0);
    do_op(0, 8'hFF, 8'h01, 1'b0, "t2a", c_r, co_r, t0);
    do_op(0, 8'hFF, 8'h00, 1'b1, "t2b", c_r, co_r, t0);

    // Stall in DONE with new operands offered; nothing may move
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 8'h5A; bv[0] = 8'h3C; cv[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    cyc = 0;
    while (!ov[0] && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t3_latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv[0] = (i >= 3 && i <= 5);
      av[0] = 8'($urandom);
      bv[0] = 8'($urandom);
      cv[0] = 1'b1;
      check("t3_hold_ov", 32'(ov[0]), 32'd1);
      check("t3_hold_c", 32'(cr[0]), 32'h96);
      check("t3_hold_cout", 32'(co[0]), 32'd0);
      check("t3_hold_ir", 32'(ir[0]), 32'd0);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    check("t3_rel_ov", 32'(ov[0]), 32'd0);
    check("t3_rel_ir", 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;
    check("t3_no_queue_ir", 32'(ir[0]), 32'd1);
    check("t3_no_queue_ov", 32'(ov[0]), 32'd0);

    // Reset during the second RUN clock
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 8'hC3; bv[0] = 8'h7E; cv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    #1;
    check("t4_rst_ir", 32'(ir[0]), 32'd1);
    check("t4_rst_ov", 32'(ov[0]), 32'd0);
    check("t4_rst_c", 32'(cr[0]), 32'd0);
    check("t4_rst_cout", 32'(co[0]), 32'd0);
    @(negedge clk);
    rst0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_no_ov", 32'(ov[0]), 32'd0);
    end
    do_op(0, 8'h81, 8'h92, 1'b1, "t4_after", c_r, co_r, t0);

    // Randomized sums on both widths
    for (int i = 0; i < 20; i++) begin
      do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), "rnd0", c_r, co_r, t0);
    end
    for (int i = 0; i < 10; i++) begin
      do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), "rnd1", c_r, co_r, t0);
    end

    // Inverse of a subtractor: (a - b - bin) + b + bin == a
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      d  = {1'b0, ra} - {1'b0, rb} - {8'd0, rc};
      do_op(0, d[7:0], rb, rc, "t5", c_r, co_r, t0);
      check("t5_inverse", 32'(c_r), 32'(ra));
    end

    // DIGIT == WIDTH: latency 1, back-to-back spacing NDIG+2 = 3 clocks
    do_op(1, 8'h80, 8'h80, 1'b1, "t6a", c_r, co_r, t0);
    check("t6a_c_const", 32'(c_r), 32'h01);
    check("t6a_cout_const", 32'(co_r), 32'd1);
    do_op(1, 8'h12, 8'h34, 1'b0, "t6b", c_r, co_r, t1);
    check("t6_spacing", 32'(t1 - t0), 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
